// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding with load-use interlock and per-operand hold buffer
module fwd_hazard_unit #(
  parameter int NSRC  = 2,
  parameter int NSTG  = 2,
  parameter int REGW  = 5,
  parameter int DATAW = 32,
  parameter int CNTW  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ex_valid,
  input  logic                  ex_stall,
  input  logic                  flush,
  input  logic [NSRC*REGW-1:0]  rsel_ex,
  input  logic [NSTG*REGW-1:0]  dsel,
  input  logic [NSTG-1:0]       dwen,
  input  logic [NSTG-1:0]       dload,
  input  logic [NSTG*DATAW-1:0] dval,
  output logic [NSRC-1:0]       fwd_use,
  output logic [NSRC*DATAW-1:0] fwd_data,
  output logic                  hazard_stall,
  output logic [CNTW-1:0]       stall_cnt
);
  logic [NSRC-1:0] unresolved;
  logic advance;
  assign hazard_stall = ex_valid & ~flush & (|unresolved);
  assign advance = (ex_valid & ~ex_stall & ~hazard_stall) | flush;
  genvar i;
  generate
    for (i = 0; i < NSRC; i++) begin : g_op
      logic [REGW-1:0]  rsel;
      logic             hit, hitLoad, holdValid, capture;
      logic [DATAW-1:0] hitData, holdData;
      assign rsel = rsel_ex[i*REGW +: REGW];
      // Scan from the farthest stage inward so the nearest match overwrites.
      always_comb begin
        hit = 1'b0;
        hitLoad = 1'b0;
        hitData = '0;
        for (int k = NSTG - 1; k >= 0; k--)
          if (dwen[k] && dsel[k*REGW +: REGW] == rsel && rsel != '0) begin
            hit = 1'b1;
            hitLoad = dload[k];
            hitData = dval[k*DATAW +: DATAW];
          end
      end
      assign capture = ~holdValid & hit & ~hitLoad;
      assign unresolved[i] = ~holdValid & hit & hitLoad;
      assign fwd_use[i] = holdValid | capture;
      assign fwd_data[i*DATAW +: DATAW] = holdValid ? holdData : capture ? hitData : '0;
      always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
          holdValid <= 1'b0;
          holdData <= '0;
        end else if (advance || !ex_valid) begin
          holdValid <= 1'b0;
        end else if (capture) begin
          holdValid <= 1'b1;
          holdData <= hitData;
        end
    end
  endgenerate
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) stall_cnt <= '0;
    else if (hazard_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding, interlock, hold buffer and counter saturation
module tb_fwd_hazard_unit;
  logic        CLK = 0, nRST = 0;
  logic        ex_valid = 0, ex_stall = 0, flush = 0;
  logic [9:0]  rsel_ex = '0, dsel = '0;
  logic [1:0]  dwen = '0, dload = '0;
  logic [63:0] dval = '0;
  logic [1:0]  fwd_use, satUse;
  logic [63:0] fwd_data, satData;
  logic        hazard_stall, satHaz;
  logic [15:0] stall_cnt;
  logic [1:0]  satCnt;
  int nChecks = 0, nFails = 0;

  always #5 CLK = ~CLK;

  fwd_hazard_unit dut (.CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .flush(flush), .rsel_ex(rsel_ex), .dsel(dsel), .dwen(dwen), .dload(dload), .dval(dval),
    .fwd_use(fwd_use), .fwd_data(fwd_data), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt));

  fwd_hazard_unit #(.CNTW(2)) satDut (.CLK(CLK), .nRST(nRST), .ex_valid(ex_valid),
    .ex_stall(ex_stall), .flush(flush), .rsel_ex(rsel_ex), .dsel(dsel), .dwen(dwen),
    .dload(dload), .dval(dval), .fwd_use(satUse), .fwd_data(satData),
    .hazard_stall(satHaz), .stall_cnt(satCnt));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    nChecks++; if (stall_cnt !== 16'd0) begin nFails++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    nChecks++; if (fwd_use !== 2'b00) begin nFails++; $display("FAIL reset_use got %b exp 00", fwd_use); end
    nChecks++; if (hazard_stall !== 1'b0) begin nFails++; $display("FAIL reset_haz got %b exp 0", hazard_stall); end
    tick();
    nRST = 1;
    tick();
  endtask

  task automatic test_basic();
    ex_valid = 1; rsel_ex = {5'd3, 5'd2}; dsel = {5'd3, 5'd2}; dwen = 2'b11;
    dval = {32'h22, 32'h11};
    #1;
    nChecks++; if (fwd_use !== 2'b11) begin nFails++; $display("FAIL basic_use got %b exp 11", fwd_use); end
    nChecks++; if (fwd_data !== {32'h22, 32'h11}) begin nFails++; $display("FAIL basic_data got %h exp %h", fwd_data, {32'h22, 32'h11}); end
    tick();
    dsel = {5'd2, 5'd2};
    #1;
    nChecks++; if (fwd_use !== 2'b01 || fwd_data[31:0] !== 32'h11) begin nFails++; $display("FAIL prio_stage0 got %b/%h exp 01/11", fwd_use, fwd_data[31:0]); end
    rsel_ex = {5'd2, 5'd2};
    #1;
    nChecks++; if (fwd_data !== {32'h11, 32'h11}) begin nFails++; $display("FAIL same_stage_two_ops got %h exp both 11", fwd_data); end
    tick();
  endtask

  task automatic test_reg_zero();
    rsel_ex = '0; dsel = '0; dwen = 2'b01; dval = {32'h0, 32'hFF};
    #1;
    nChecks++; if (fwd_use !== 2'b00 || fwd_data !== 64'h0) begin nFails++; $display("FAIL reg_zero got %b/%h exp 00/0", fwd_use, fwd_data); end
    tick();
  endtask

  task automatic test_load_use();
    rsel_ex = {5'd5, 5'd7}; dsel = {5'd7, 5'd5}; dwen = 2'b11; dload = 2'b01;
    dval = {32'h77, 32'hDEAD};
    #1;
    nChecks++; if (hazard_stall !== 1'b1) begin nFails++; $display("FAIL lu_haz got %b exp 1", hazard_stall); end
    nChecks++; if (fwd_use !== 2'b01 || fwd_data[31:0] !== 32'h77) begin nFails++; $display("FAIL lu_partial got %b/%h exp 01/77", fwd_use, fwd_data[31:0]); end
    tick();
    nChecks++; if (stall_cnt !== 16'd1 || satCnt !== 2'd1) begin nFails++; $display("FAIL lu_cnt got %0d/%0d exp 1/1", stall_cnt, satCnt); end
    dsel = {5'd5, 5'd0}; dwen = 2'b10; dload = 2'b00; dval = {32'hABCD, 32'h0};
    #1;
    nChecks++; if (hazard_stall !== 1'b0) begin nFails++; $display("FAIL lu_release got %b exp 0", hazard_stall); end
    nChecks++; if (fwd_use !== 2'b11 || fwd_data !== {32'hABCD, 32'h77}) begin nFails++; $display("FAIL lu_data got %b/%h exp 11/0000abcd00000077", fwd_use, fwd_data); end
    tick();
    dwen = 2'b00;
    #1;
    nChecks++; if (fwd_use !== 2'b00 || stall_cnt !== 16'd1) begin nFails++; $display("FAIL lu_after got %b/%0d exp 00/1", fwd_use, stall_cnt); end
  endtask

  task automatic test_hold_stall();
    ex_stall = 1; rsel_ex = {5'd0, 5'd4}; dsel = {5'd0, 5'd4}; dwen = 2'b01; dval = {32'h0, 32'h55};
    #1;
    nChecks++; if (fwd_use !== 2'b01 || fwd_data[31:0] !== 32'h55) begin nFails++; $display("FAIL hold_c1 got %b/%h exp 01/55", fwd_use, fwd_data[31:0]); end
    tick();
    dwen = 2'b00; dval = '0;
    for (int c = 2; c <= 3; c++) begin
      #1;
      nChecks++; if (fwd_use !== 2'b01 || fwd_data[31:0] !== 32'h55) begin nFails++; $display("FAIL hold_c%0d got %b/%h exp 01/55", c, fwd_use, fwd_data[31:0]); end
      tick();
    end
    ex_stall = 0;
    #1;
    nChecks++; if (fwd_use !== 2'b01) begin nFails++; $display("FAIL hold_last got %b exp 01", fwd_use); end
    tick();
    nChecks++; if (fwd_use !== 2'b00 || fwd_data !== 64'h0) begin nFails++; $display("FAIL hold_clear got %b/%h exp 00/0", fwd_use, fwd_data); end
  endtask

  task automatic test_flush();
    ex_stall = 1; rsel_ex = {5'd6, 5'd4}; dsel = {5'd0, 5'd4}; dwen = 2'b01; dval = {32'h0, 32'h99};
    tick();
    dsel = {5'd6, 5'd0}; dwen = 2'b10; dload = 2'b10; flush = 1;
    #1;
    nChecks++; if (hazard_stall !== 1'b0) begin nFails++; $display("FAIL flush_haz got %b exp 0", hazard_stall); end
    nChecks++; if (fwd_use !== 2'b01 || fwd_data[31:0] !== 32'h99) begin nFails++; $display("FAIL flush_pre got %b/%h exp 01/99", fwd_use, fwd_data[31:0]); end
    tick();
    flush = 0; dwen = 2'b00; dload = 2'b00;
    #1;
    nChecks++; if (fwd_use !== 2'b00 || stall_cnt !== 16'd1) begin nFails++; $display("FAIL flush_clear got %b/%0d exp 00/1", fwd_use, stall_cnt); end
    ex_stall = 0;
    tick();
  endtask

  task automatic test_saturation();
    rsel_ex = {5'd5, 5'd7}; dsel = {5'd7, 5'd5}; dwen = 2'b11; dload = 2'b01;
    dval = {32'h77, 32'h0};
    repeat (4) tick();
    dwen = 2'b01;
    #1;
    nChecks++; if (fwd_use !== 2'b01 || fwd_data[31:0] !== 32'h77 || hazard_stall !== 1'b1) begin nFails++; $display("FAIL sat_hold got %b/%h/%b exp 01/77/1", fwd_use, fwd_data[31:0], hazard_stall); end
    tick();
    nChecks++; if (satCnt !== 2'd3) begin nFails++; $display("FAIL sat_cnt got %0d exp 3", satCnt); end
    nChecks++; if (stall_cnt !== 16'd6) begin nFails++; $display("FAIL wide_cnt got %0d exp 6", stall_cnt); end
    #2 nRST = 0;
    #1;
    nChecks++; if (stall_cnt !== 16'd0 || satCnt !== 2'd0) begin nFails++; $display("FAIL async_cnt got %0d/%0d exp 0/0", stall_cnt, satCnt); end
    nChecks++; if (fwd_use !== 2'b00 || satHaz !== 1'b1) begin nFails++; $display("FAIL async_hold got %b/%b exp 00/1", fwd_use, satHaz); end
    nRST = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reg_zero();
    test_load_use();
    test_hold_stall();
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
